// File: rtl/priv_pkg.sv
// priv_pkg: privilege modes, trap causes, CSR addresses, mstatus bit indices and FSM states
package priv_pkg;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_R = 2'b10;
  localparam logic [1:0] MODE_M = 2'b11;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_S = 4'd9;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_EXT = 4'd11;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;
  localparam int MS_SPP  = 8;
  localparam int MS_MPP  = 11;
  localparam int MS_TSR  = 22;
  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_WFI} state_t;
  typedef enum logic [1:0] {RD_TRAP, RD_MRET, RD_SRET} redir_t;
  function automatic logic [3:0] ecall_cause(input logic [1:0] mode);
    return mode == MODE_M ? CAUSE_ECALL_M : mode == MODE_S ? CAUSE_ECALL_S : CAUSE_ECALL_U;
  endfunction
endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file: machine trap CSR storage, write decode and combinational read mux
module trap_csr_file
  import priv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            we,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic [1:0]      cur_mode,
  input  logic            do_mret,
  input  logic            do_sret,
  output logic            mie,
  output logic [1:0]      mpp,
  output logic            spp,
  output logic            tsr,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] sepc
);
  logic mpie;
  logic [XLEN-1:0] mcause, mtval, mstatus;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mpp    <= MODE_U;
      spp    <= 1'b0;
      tsr    <= 1'b0;
      mtvec  <= RESET_VEC;
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
      sepc   <= '0;
    end else if (trap) begin
      mepc   <= {trap_epc[XLEN-1:1], 1'b0};
      mcause <= trap_cause;
      mtval  <= trap_tval;
      mpie   <= mie;
      mie    <= 1'b0;
      mpp    <= cur_mode;
    end else if (do_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
      mpp  <= MODE_U;
    end else if (do_sret) begin
      spp <= 1'b0;
    end else if (we) begin
      if (addr == CSR_MSTATUS) begin
        mie  <= wdata[MS_MIE];
        mpie <= wdata[MS_MPIE];
        spp  <= wdata[MS_SPP];
        mpp  <= wdata[MS_MPP +: 2] == MODE_R ? MODE_U : wdata[MS_MPP +: 2];
        tsr  <= wdata[MS_TSR];
      end
      if (addr == CSR_MTVEC)  mtvec  <= wdata;
      if (addr == CSR_MEPC)   mepc   <= {wdata[XLEN-1:1], 1'b0};
      if (addr == CSR_MCAUSE) mcause <= wdata;
      if (addr == CSR_MTVAL)  mtval  <= wdata;
      if (addr == CSR_SEPC)   sepc   <= {wdata[XLEN-1:1], 1'b0};
    end
  end
  always_comb begin
    mstatus = '0;
    mstatus[MS_MIE] = mie;
    mstatus[MS_MPIE] = mpie;
    mstatus[MS_SPP] = spp;
    mstatus[MS_MPP +: 2] = mpp;
    mstatus[MS_TSR] = tsr;
  end
  assign rdata = addr == CSR_MSTATUS ? mstatus :
                 addr == CSR_MTVEC   ? mtvec   :
                 addr == CSR_MEPC    ? mepc    :
                 addr == CSR_MCAUSE  ? mcause  :
                 addr == CSR_MTVAL   ? mtval   :
                 addr == CSR_SEPC    ? sepc    : '0;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap/privilege FSM with PC redirect and flush.
// TRAP_IRQ_EN enables the external interrupt path, WFI_WAIT and stall.
module trap_ctrl
  import priv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_instr,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            uret,
  input  logic            sret,
  input  logic            mret,
  input  logic            wfi,
  input  logic            illegal_instr,
  input  logic            irq_ext,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [1:0]      current_mode,
  output logic            exception_pending,
  output logic            TSR,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            stall
);
  state_t state, state_nx;
  redir_t kind, kind_nx;
  logic [1:0] mode, mode_nx, mpp;
  logic trap, irq, do_mret, do_sret, irq_run, irq_wfi, wake, mie, spp, tsr;
  logic [3:0] code;
  logic [XLEN-1:0] epc, tval, mtvec, mepc, sepc, resume_pc;
`ifdef TRAP_IRQ_EN
  localparam logic WFI_EN = 1'b1;
  assign irq_run = irq_ext & (mie | (mode != MODE_M));
  assign irq_wfi = irq_ext & mie;
  assign wake = irq_ext;
  assign stall = state == ST_WFI;
  // the interrupt that ends a WFI resumes after the wfi itself
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) resume_pc <= '0;
    else if (state == ST_RUN && state_nx == ST_WFI) resume_pc <= commit_pc + XLEN'(4);
`else
  localparam logic WFI_EN = 1'b0;
  logic unused_irq;
  assign unused_irq = irq_ext ^ mie;
  assign irq_run = 1'b0;
  assign irq_wfi = 1'b0;
  assign wake = 1'b0;
  assign stall = 1'b0;
  assign resume_pc = '0;
`endif
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= ST_RUN;
      kind  <= RD_TRAP;
      mode  <= MODE_M;
    end else begin
      state <= state_nx;
      kind  <= kind_nx;
      mode  <= mode_nx;
    end
  always_comb begin
    state_nx = state;
    kind_nx = kind;
    mode_nx = mode;
    trap = 1'b0;
    irq = 1'b0;
    code = CAUSE_ILLEGAL;
    epc = commit_pc;
    tval = '0;
    do_mret = 1'b0;
    do_sret = 1'b0;
    if (state == ST_TRAP) state_nx = ST_RUN;
    else if (state == ST_WFI) begin
      if (wake) begin
        trap = irq_wfi;
        irq = irq_wfi;
        code = CAUSE_IRQ_EXT;
        epc = resume_pc;
        state_nx = ST_RUN;
      end
    end else if (irq_run) begin
      trap = 1'b1;
      irq = 1'b1;
      code = CAUSE_IRQ_EXT;
    end else if (commit_valid) begin
      if (illegal_instr) begin
        trap = 1'b1;
        tval = XLEN'(commit_instr);
      end else if (ebreak) begin
        trap = 1'b1;
        code = CAUSE_BREAK;
      end else if (ecall) begin
        trap = 1'b1;
        code = ecall_cause(mode);
      end else if (mret) begin
        do_mret = 1'b1;
        mode_nx = mpp;
        kind_nx = RD_MRET;
        state_nx = ST_TRAP;
      end else if (sret) begin
        do_sret = 1'b1;
        mode_nx = {1'b0, spp};
        kind_nx = RD_SRET;
        state_nx = ST_TRAP;
      end else if (uret) trap = 1'b1;
      else if (wfi && WFI_EN) state_nx = ST_WFI;
    end
    if (trap) begin
      mode_nx = MODE_M;
      kind_nx = RD_TRAP;
      state_nx = ST_TRAP;
    end
  end
  trap_csr_file #(.XLEN(XLEN), .RESET_VEC(RESET_VEC)) u_csr (
    .clk       (clk),
    .nrst      (nrst),
    .we        (csr_we & ~(trap | do_mret | do_sret)),
    .addr      (csr_addr),
    .wdata     (csr_wdata),
    .rdata     (csr_rdata),
    .trap      (trap),
    .trap_cause({irq, {(XLEN-5){1'b0}}, code}),
    .trap_epc  (epc),
    .trap_tval (tval),
    .cur_mode  (mode),
    .do_mret   (do_mret),
    .do_sret   (do_sret),
    .mie       (mie),
    .mpp       (mpp),
    .spp       (spp),
    .tsr       (tsr),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .sepc      (sepc)
  );
  assign current_mode = mode;
  assign TSR = tsr;
  assign redirect_valid = state == ST_TRAP;
  assign flush = redirect_valid;
  assign exception_pending = redirect_valid && kind == RD_TRAP;
  assign redirect_pc = !redirect_valid ? '0 :
                       kind == RD_MRET ? mepc :
                       kind == RD_SRET ? sepc : {mtvec[XLEN-1:2], 2'b00};
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus with a redirect scoreboard for trap_ctrl
module tb_trap_ctrl;
  logic clk = 1'b0, nrst = 1'b0;
  logic commit_valid = 1'b0, ecall = 1'b0, ebreak = 1'b0, uret = 1'b0, sret = 1'b0;
  logic mret = 1'b0, wfi = 1'b0, illegal_instr = 1'b0, irq_ext = 1'b0, csr_we = 1'b0;
  logic [31:0] commit_pc = '0, commit_instr = '0, csr_wdata = '0, csr_rdata, redirect_pc;
  logic [11:0] csr_addr = '0;
  logic [1:0] current_mode;
  logic exception_pending, TSR, redirect_valid, flush, stall;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] pc; logic ep; logic [1:0] mode;} exp_t;
  exp_t q[$];
  localparam logic [6:0] F_ECALL = 7'b1000000, F_EBREAK = 7'b0100000, F_URET = 7'b0010000;
  localparam logic [6:0] F_SRET = 7'b0001000, F_MRET = 7'b0000100, F_WFI = 7'b0000010, F_ILL = 7'b0000001;

  trap_ctrl dut (
    .clk(clk), .nrst(nrst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .ecall(ecall), .ebreak(ebreak), .uret(uret), .sret(sret),
    .mret(mret), .wfi(wfi), .illegal_instr(illegal_instr), .irq_ext(irq_ext),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .current_mode(current_mode), .exception_pending(exception_pending), .TSR(TSR),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string n, input logic [11:0] a, input logic [31:0] e);
    csr_addr = a;
    #1;
    chk(n, csr_rdata, e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1;
    csr_addr = a;
    csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] ins, input logic [6:0] f);
    commit_valid = 1'b1;
    commit_pc = pc;
    commit_instr = ins;
    {ecall, ebreak, uret, sret, mret, wfi, illegal_instr} = f;
    tick();
    commit_valid = 1'b0;
    {ecall, ebreak, uret, sret, mret, wfi, illegal_instr} = '0;
  endtask

  task automatic expect_redirect(input logic [31:0] pc, input logic ep, input logic [1:0] m);
    q.push_back('{pc: pc, ep: ep, mode: m});
  endtask

  always @(negedge clk)
    if (nrst && redirect_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect got_pc=%h exp=none", redirect_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("exception_pending", {31'b0, exception_pending}, {31'b0, e.ep});
        chk("trap_mode", {30'b0, current_mode}, {30'b0, e.mode});
        chk("flush", {31'b0, flush}, 32'd1);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    nrst = 1'b1;
    #1;
    chk("rst_mode", {30'b0, current_mode}, 32'd3);
    chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
    chk("rst_exc", {31'b0, exception_pending}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_tsr", {31'b0, TSR}, 32'd0);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    tick();
    // drop to U via mret with MPP=00, then U-mode ecall
    wr(12'h305, 32'h200);
    wr(12'h341, 32'h80);
    expect_redirect(32'h80, 1'b0, 2'b00);
    commit(32'h10, 32'h0, F_MRET);
    tick();
    chk("u_mode", {30'b0, current_mode}, 32'd0);
    expect_redirect(32'h200, 1'b1, 2'b11);
    commit(32'h100, 32'h0, F_ECALL);
    tick();
    rd("ecall_u_mcause", 12'h342, 32'd8);
    rd("ecall_u_mepc", 12'h341, 32'h100);
    rd("ecall_u_mstatus", 12'h300, 32'h0);
    chk("ecall_u_mode", {30'b0, current_mode}, 32'd3);
    // illegal beats ebreak
    expect_redirect(32'h200, 1'b1, 2'b11);
    commit(32'h104, 32'hFFFF_FFFF, F_ILL | F_EBREAK);
    tick();
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    rd("ill_mepc", 12'h341, 32'h104);
    rd("ill_mstatus", 12'h300, 32'h1800);
    // mret into S with MPIE=1, TSR set
    wr(12'h300, 32'h0040_0880);
    wr(12'h341, 32'h340);
    chk("tsr_out", {31'b0, TSR}, 32'd1);
    expect_redirect(32'h340, 1'b0, 2'b01);
    commit(32'h50, 32'h0, F_MRET);
    tick();
    chk("mret_mode", {30'b0, current_mode}, 32'd1);
    rd("mret_mstatus", 12'h300, 32'h0040_0088);
    // sret with SPP=1, odd sepc
    wr(12'h141, 32'h777);
    rd("sepc_bit0", 12'h141, 32'h776);
    wr(12'h300, 32'h0040_0108);
    expect_redirect(32'h776, 1'b0, 2'b01);
    commit(32'h60, 32'h0, F_SRET);
    tick();
    chk("sret_mode", {30'b0, current_mode}, 32'd1);
    rd("sret_mstatus", 12'h300, 32'h0040_0008);
    // uret from S is an illegal trap without mtval
    expect_redirect(32'h200, 1'b1, 2'b11);
    commit(32'h64, 32'h1234_5678, F_URET);
    tick();
    rd("uret_mcause", 12'h342, 32'd2);
    rd("uret_mtval", 12'h343, 32'h0);
    rd("uret_mepc", 12'h341, 32'h64);
    rd("uret_mstatus", 12'h300, 32'h0040_0880);
    // misaligned mtvec, M-mode ecall outranks mret
    wr(12'h305, 32'h203);
    rd("mtvec_read", 12'h305, 32'h203);
    expect_redirect(32'h200, 1'b1, 2'b11);
    commit(32'h70, 32'h0, F_ECALL | F_MRET);
    tick();
    rd("ecall_m_mcause", 12'h342, 32'd11);
    rd("ecall_m_mstatus", 12'h300, 32'h0040_1800);
    // flags without commit_valid are ignored
    ecall = 1'b1;
    tick();
    ecall = 1'b0;
    tick();
    rd("novalid_mepc", 12'h341, 32'h70);
    // CSR write coincident with a trap is dropped
    csr_we = 1'b1;
    csr_addr = 12'h341;
    csr_wdata = 32'h9999;
    expect_redirect(32'h200, 1'b1, 2'b11);
    commit(32'h80, 32'h0, F_ECALL);
    csr_we = 1'b0;
    tick();
    rd("drop_mepc", 12'h341, 32'h80);
    wr(12'h341, 32'h1235);
    rd("mepc_write", 12'h341, 32'h1234);
`ifdef TRAP_IRQ_EN
    wr(12'h300, 32'h8);
    commit(32'h90, 32'h0, F_WFI);
    for (int i = 0; i < 5; i++) begin
      chk("wfi_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    irq_ext = 1'b1;
    expect_redirect(32'h200, 1'b1, 2'b11);
    tick();
    irq_ext = 1'b0;
    chk("irq_stall_clear", {31'b0, stall}, 32'd0);
    tick();
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc", 12'h341, 32'h94);
    rd("irq_mstatus", 12'h300, 32'h1880);
    commit(32'hA0, 32'h0, F_WFI);
    chk("wfi2_stall", {31'b0, stall}, 32'd1);
    irq_ext = 1'b1;
    tick();
    irq_ext = 1'b0;
    chk("wake_nomie_stall", {31'b0, stall}, 32'd0);
    tick();
    rd("wake_nomie_mcause", 12'h342, 32'h8000_000B);
`else
    commit(32'h90, 32'h0, F_WFI);
    chk("wfi_nop_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("wfi_nop_mode", {30'b0, current_mode}, 32'd3);
    rd("wfi_nop_mcause", 12'h342, 32'd11);
`endif
    // reset in the TRAP cycle clears outputs immediately
    commit(32'hB0, 32'h0, F_ECALL);
    #1;
    chk("pre_rst_redirect", {31'b0, redirect_valid}, 32'd1);
    chk("pre_rst_exc", {31'b0, exception_pending}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("midtrap_redirect", {31'b0, redirect_valid}, 32'd0);
    chk("midtrap_exc", {31'b0, exception_pending}, 32'd0);
    chk("midtrap_mode", {30'b0, current_mode}, 32'd3);
    rd("midtrap_mtvec", 12'h305, 32'h0);
    rd("midtrap_mepc", 12'h341, 32'h0);
    nrst = 1'b1;
    tick();
    tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
